pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter ADDR_W, default 4: instruction address width.
REQ-003 Parameter DATA_W, default 8: instruction word width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  leave IDLE or HALTED and begin fetching.
REQ-007 halt  input  1  stop fetching after the current issue handshake.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  ADDR_W  fetch address, equal to the internal PC.
REQ-010 imem_ack  input  1  memory read complete; imem_rdata is valid.
REQ-011 imem_rdata  input  DATA_W  fetched instruction word.
REQ-012 instr  output  DATA_W  registered instruction to the decoder.
REQ-013 instr_valid  output  1  instr is valid.
REQ-014 instr_ready  input  1  the decoder accepts instr.
REQ-015 br_valid  input  1  taken branch, qualified at the issue handshake.
REQ-016 br_target  input  ADDR_W  branch destination address.
REQ-017 busy  output  1  high in the REQ and ISSUE states.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, ISSUE and HALTED.
REQ-019 IDLE: start=1 SHALL go to REQ on the next edge; all other inputs are ignored.
REQ-020 REQ: imem_req SHALL be 1 and imem_addr SHALL equal the PC; both SHALL be held stable until imem_ack=1.
REQ-021 REQ with imem_ack=1: the block SHALL register imem_rdata into instr and go to ISSUE.
REQ-022 imem_ack SHALL be ignored outside REQ.
REQ-023 ISSUE: instr_valid SHALL be 1 and instr SHALL be held stable until instr_ready=1 (the handshake).
REQ-024 At the handshake the PC SHALL update: br_target if br_valid=1, else PC+1 modulo 2^ADDR_W (address 15 wraps to 0; no carry out).
REQ-025 At the handshake the next state SHALL be HALTED if halt=1, else REQ.
REQ-026 br_valid and halt SHALL be ignored except on the handshake cycle.
REQ-027 br_valid=1 and halt=1 on the same handshake: the PC SHALL load br_target and the state SHALL go to HALTED.
REQ-028 HALTED: start=1 SHALL go to REQ with the PC unchanged; the PC SHALL be held otherwise.
REQ-029 start SHALL be ignored in REQ and ISSUE.
REQ-030 Latency: start sampled at edge N gives imem_req=1 after edge N.
REQ-031 Latency: imem_ack sampled at edge M gives instr_valid=1 after edge M.
REQ-032 Throughput: at least 2 cycles per instruction (one REQ cycle plus one ISSUE cycle).
REQ-033 imem_req and instr_valid SHALL never be high in the same cycle.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL set state=IDLE, PC=0, instr=0, instr_valid=0, imem_req=0 and busy=0.
REQ-035 rst SHALL override every other input in every state, including mid-REQ and mid-ISSUE; any pending fetch or unissued instruction is discarded.
REQ-036 An imem_ack arriving after reset SHALL be ignored (the block is in IDLE).

Configuration
REQ-037 The macro PC_SEQUENCER_BRANCH_EN SHALL control branch support.
REQ-038 With PC_SEQUENCER_BRANCH_EN defined, branch behaviour SHALL follow REQ-024 and REQ-027.
REQ-039 Without it, br_valid and br_target SHALL remain as ports but be ignored; the PC SHALL always advance by PC+1 with wrap.

Verification
REQ-040 Reset, then start pulse, imem_ack on the first REQ cycle, instr_ready=1 -> imem_addr sequence 0,1,2,...; instr_valid first seen 2 cycles after start.
REQ-041 PC=15, handshake with no branch -> next imem_addr=0.
REQ-042 imem_ack delayed 3 cycles -> imem_req and imem_addr=PC held stable for 4 cycles.
REQ-043 instr_ready delayed 2 cycles -> instr held stable; PC changes only after ready.
REQ-044 Handshake at PC=5 with br_valid=1, br_target=12 and halt=1 -> HALTED; start -> imem_addr=12. Without the macro, the same stimulus gives imem_addr=6.
REQ-045 rst asserted during ISSUE -> next cycle IDLE, PC=0, instr_valid=0; a later imem_ack=1 causes no change.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: IDLE -> REQ (wait imem_ack) -> ISSUE (wait instr_ready) -> REQ/HALTED.
// 1 cycle start->req and ack->valid; req and instr held until handshake; PC_SEQUENCER_BRANCH_EN enables branches.
module pc_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_q;
  logic              req_q;
  logic              vld_q;
  logic              busy_q;

  // Post-handshake PC; the increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
`ifdef PC_SEQUENCER_BRANCH_EN
    if (br_valid) begin
      pc_d = br_target;
    end
`endif
  end

`ifndef PC_SEQUENCER_BRANCH_EN
  logic unused_br;
  assign unused_br = ^{br_valid, br_target};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state_q <= ISSUE;
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc_q  <= pc_d;
            vld_q <= 1'b0;
            if (halt) begin
              state_q <= HALTED;
              busy_q  <= 1'b0;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign busy        = busy_q;

endmodule
